// File: rtl/regfile_wr_decoder_if.sv
// regfile_wr_decoder_if
//   Bundles the write-port decode signals between the issuing stage
//   (master) and the write-enable decoder (slave).
//   write_enable : global write strobe, master -> slave
//   in[4:0]      : destination register index, master -> slave
//   out[31:0]    : registered one-hot write-enable vector, slave -> master
interface regfile_wr_decoder_if;
  logic        write_enable;
  logic [4:0]  in;
  logic [31:0] out;

  modport master (output write_enable, output in, input  out);
  modport slave  (input  write_enable, input  in, output out);
endinterface

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder
//   Registered 5-to-32 write-enable decoder. A 2-to-4 predecoder on
//   in[4:3] selects one of four 3-to-8 group decoders on in[2:0]; the
//   selected group bit is ANDed with write_enable and captured in an
//   output register. Latency is one cycle; out is one-hot or zero.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears out immediately
//   bus   : regfile_wr_decoder_if.slave (write_enable, in, out)
// Configuration
//   DEC_GATE_DELAY_EN : when defined, every decode gate carries a 50 ps
//   delay for gate-level timing simulation (3 levels, <=150 ps total).
//   Undefined (default) gives zero-delay gates. Register behaviour is
//   the same in both builds.

`ifdef DEC_GATE_DELAY_EN
  `define RWD_GDLY #(50ps)
`else
  `define RWD_GDLY
`endif

// One 3-to-8 group decoder; each output is a single decode gate.
module regfile_wr_dec3to8 (
  input  logic [2:0] i_a,
  output logic [7:0] o_y
);
  for (genvar j = 0; j < 8; j++) begin : g_bit
    assign `RWD_GDLY o_y[j] = (i_a == 3'(j));
  end
endmodule

module regfile_wr_decoder (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wr_decoder_if.slave bus
);
  localparam int NUM_GRP = 4;
  localparam int GRP_W   = 8;

  logic [NUM_GRP-1:0]            w_en4;
  logic [NUM_GRP-1:0][GRP_W-1:0] w_temp;
  logic [NUM_GRP-1:0][GRP_W-1:0] w_dec;
  logic [NUM_GRP-1:0][GRP_W-1:0] w_next;
  logic [31:0]                   r_out;

  // Level 1a: upper-bit predecode, one-hot over the four groups.
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_pre
    assign `RWD_GDLY w_en4[g] = (bus.in[4:3] == 2'(g));
  end

  // Level 1b: identical low-bit decoders, one per group.
  regfile_wr_dec3to8 u_grp [NUM_GRP-1:0] (
    .i_a (bus.in[2:0]),
    .o_y (w_temp)
  );

  // Levels 2 and 3: group gating, then global enable gating.
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    for (genvar j = 0; j < GRP_W; j++) begin : g_bit
      assign `RWD_GDLY w_dec[g][j]  = w_en4[g] & w_temp[g][j];
      assign `RWD_GDLY w_next[g][j] = w_dec[g][j] & bus.write_enable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= 32'h0;
    else        r_out <= w_next;
  end

  assign bus.out = r_out;
endmodule

`undef RWD_GDLY

// File: tb/tb_regfile_wr_decoder.sv
module tb_regfile_wr_decoder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_wr_decoder_if bus ();

  regfile_wr_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: register k is written iff enabled and k equals the index.
  function automatic logic [31:0] ref_vec(input logic we, input int idx);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 32; k++)
      if (we && k == idx) v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at falling edge, check 1 time unit after the capturing edge.
  task automatic step(input string tag, input logic we, input int idx);
    @(negedge clk);
    bus.write_enable = we;
    bus.in           = 5'(idx);
    @(posedge clk);
    #1;
    chk(tag, bus.out, ref_vec(we, idx));
  endtask

  initial begin
    logic [31:0] prev;
    int          idx;
    logic        we;
    checks = 0;
    errors = 0;

    // Reset held with active inputs: output stays zero.
    rst_n = 1'b0;
    bus.write_enable = 1'b1;
    bus.in = 5'd5;
    #1;
    chk("reset_async", bus.out, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_hold", bus.out, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", bus.out, 32'h0000_0020);

    // Disabled: no bit may assert.
    step("disabled_0", 1'b0, 0);
    step("disabled_1", 1'b0, 1);
    step("disabled_31", 1'b0, 31);

    // Exhaustive decode, back-to-back, with one-hot check.
    for (int i = 0; i < 32; i++) begin
      step($sformatf("exh_%0d", i), 1'b1, i);
      chk("exh_onehot", 32'($countones(bus.out)), 32'd1);
    end
    chk("exh_bit31", bus.out, 32'h8000_0000);

    // Enable toggle on a held index.
    step("tog_a", 1'b1, 17);
    chk("tog_a_val", bus.out, 32'h0002_0000);
    step("tog_b", 1'b0, 17);
    step("tog_c", 1'b1, 17);
    chk("tog_c_val", bus.out, 32'h0002_0000);

    // Randomized stream.
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(31, 0));
      we  = ($urandom_range(3, 0) != 0);
      step("rand", we, idx);
    end

    // Mid-run reset pulsed between edges.
    step("mid_pre", 1'b1, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_clear", bus.out, 32'h0);
    @(posedge clk); #1;
    chk("mid_hold", bus.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.write_enable = 1'b1;
    bus.in = 5'd30;
    @(posedge clk); #1;
    chk("mid_resume", bus.out, 32'h4000_0000);
    step("mid_next", 1'b1, 2);

    // Input change between edges must not disturb the registered value.
    @(negedge clk);
    prev = bus.out;
    bus.in = 5'd12;
    #2;
    chk("between_edges_hold", bus.out, prev);
    @(posedge clk); #1;
    chk("between_edges_capture", bus.out, 32'h0000_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
